// File: rtl/wb_write_arbiter_if.sv
// Bundle for the register-file write arbiter: pipeline and long-latency write
// sources, ID busy lookups, and the register-file write port.
interface wb_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic              lu_ready;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic              busy1;
  logic              busy2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output lu_valid, lu_waddr, lu_wdata,
    output re1, raddr1, re2, raddr2,
    input  lu_ready, busy1, busy2, we, waddr, wdata, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  lu_valid, lu_waddr, lu_wdata,
    input  re1, raddr1, re2, raddr2,
    output lu_ready, busy1, busy2, we, waddr, wdata, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Owns the register file's single write port: pipeline writes win, long-latency
// results queue in a small FIFO and drain into idle cycles; exposes busy lookups.
module wb_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  live_r;
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;

  logic pipe_take_s;
  logic push_s;
  logic pop_s;
  logic lu_ready_s;
  logic hit1_s;
  logic hit2_s;
  logic enq_squash_s;

  // No pop-to-push bypass: readiness comes only from the registered count.
  assign lu_ready_s   = (count_r != FULL_CNT);
  assign pipe_take_s  = bus.pipe_we && (bus.pipe_waddr != {ADDR_W{1'b0}});
  assign push_s       = bus.lu_valid && lu_ready_s && (bus.lu_waddr != {ADDR_W{1'b0}});
  assign pop_s        = !pipe_take_s && (count_r != {CNT_W{1'b0}});
  assign enq_squash_s = pipe_take_s && (bus.lu_waddr == bus.pipe_waddr);

  // Pending-destination lookup over live entries only
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1_s = hit1_s | (live_r[i] && (addr_r[i] == bus.raddr1));
      hit2_s = hit2_s | (live_r[i] && (addr_r[i] == bus.raddr2));
    end
  end

  // FIFO storage, pointers, occupancy and squash of older pending writes
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      live_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {ADDR_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      // Pipeline results are younger, so they kill any matching queued write.
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_take_s && live_r[i] && (addr_r[i] == bus.pipe_waddr)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[head_r] <= 1'b0;
        head_r         <= head_r + PTR_W'(1);
      end
      if (push_s) begin
        live_r[tail_r] <= !enq_squash_s;
        addr_r[tail_r] <= bus.lu_waddr;
        data_r[tail_r] <= bus.lu_wdata;
        tail_r         <= tail_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered write-port selection: pipeline first, then FIFO head
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (pipe_take_s) begin
      we_r    <= 1'b1;
      waddr_r <= bus.pipe_waddr;
      wdata_r <= bus.pipe_wdata;
    end else if (pop_s) begin
      we_r    <= live_r[head_r];
      waddr_r <= addr_r[head_r];
      wdata_r <= data_r[head_r];
    end else begin
      we_r    <= 1'b0;
    end
  end

  assign bus.lu_ready   = lu_ready_s;
  assign bus.busy1      = bus.re1 && (bus.raddr1 != {ADDR_W{1'b0}}) && hit1_s;
  assign bus.busy2      = bus.re2 && (bus.raddr2 != {ADDR_W{1'b0}}) && hit2_s;
  assign bus.we         = we_r;
  assign bus.waddr      = waddr_r;
  assign bus.wdata      = wdata_r;
  assign bus.fifo_count = count_r;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected writes go into a scoreboard
// queue as stimulus is issued; a negedge monitor pops and compares every write.
module tb_wb_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
  wb_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic pipe(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.pipe_we    = en;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
  endtask

  task automatic lu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.lu_valid = v;
    bus.lu_waddr = a;
    bus.lu_wdata = d;
  endtask

  // Scoreboard monitor: every issued write must match the next expected one
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write",
                 bus.waddr, bus.wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.waddr !== mon_e.a || bus.wdata !== mon_e.d) begin
          fails++;
          $display("FAIL write_port: got addr %0d data 0x%0h, required addr %0d data 0x%0h",
                   bus.waddr, bus.wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b1, 5'd3, 32'h33);
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    bus.re2 = 1'b0; bus.raddr2 = 5'd0;

    // Reset held two cycles with lu_valid asserted
    tick(); tick(); settle();
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("rst_busy1", 32'(bus.busy1), 32'd0);
    rst = 1'b0;
    lu(1'b0, 5'd0, 32'h0);
    tick(); settle();
    chk("rst_no_enqueue", 32'(bus.fifo_count), 32'd0);

    // Pipeline-only write, one-cycle latency
    pipe(1'b1, 5'd5, 32'h1234); expect_wr(5'd5, 32'h1234);
    tick();
    pipe(1'b0, 5'd0, 32'h0); settle();
    chk("pipe_we", 32'(bus.we), 32'd1);
    chk("pipe_waddr", 32'(bus.waddr), 32'd5);
    chk("pipe_count", 32'(bus.fifo_count), 32'd0);

    // Drain: result waits behind three pipeline writes
    bus.raddr1 = 5'd7;
    pipe(1'b1, 5'd10, 32'h10); lu(1'b1, 5'd7, 32'hAAAA); expect_wr(5'd10, 32'h10);
    tick();
    lu(1'b0, 5'd0, 32'h0); pipe(1'b1, 5'd11, 32'h11); expect_wr(5'd11, 32'h11); settle();
    chk("drain_count", 32'(bus.fifo_count), 32'd1);
    chk("drain_busy_a", 32'(bus.busy1), 32'd1);
    tick();
    pipe(1'b1, 5'd12, 32'h12); expect_wr(5'd12, 32'h12); settle();
    chk("drain_busy_b", 32'(bus.busy1), 32'd1);
    tick();
    pipe(1'b0, 5'd0, 32'h0); expect_wr(5'd7, 32'hAAAA); settle();
    chk("drain_busy_pop", 32'(bus.busy1), 32'd1);
    chk("drain_count_pop", 32'(bus.fifo_count), 32'd1);
    tick(); settle();
    chk("drain_empty", 32'(bus.fifo_count), 32'd0);
    chk("drain_busy_clear", 32'(bus.busy1), 32'd0);

    // Full: four pushes under constant pipeline traffic, fifth held
    for (int i = 0; i < 4; i++) begin
      pipe(1'b1, ADDR_W'(16 + i), DATA_W'(32'h200 + i));
      expect_wr(ADDR_W'(16 + i), DATA_W'(32'h200 + i));
      lu(1'b1, ADDR_W'(i + 1), DATA_W'(32'h100 + i));
      tick();
    end
    pipe(1'b1, 5'd24, 32'h224); expect_wr(5'd24, 32'h224);
    lu(1'b1, 5'd5, 32'h105); settle();
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_lu_ready", 32'(bus.lu_ready), 32'd0);
    tick();
    pipe(1'b0, 5'd0, 32'h0); expect_wr(5'd1, 32'h100); settle();
    chk("full_no_bypass", 32'(bus.lu_ready), 32'd0);
    chk("full_count_hold", 32'(bus.fifo_count), 32'd4);
    tick();
    expect_wr(5'd2, 32'h101); settle();
    chk("full_ready_again", 32'(bus.lu_ready), 32'd1);
    chk("full_count_3", 32'(bus.fifo_count), 32'd3);
    tick();
    lu(1'b0, 5'd0, 32'h0); expect_wr(5'd3, 32'h102); settle();
    chk("full_push_pop", 32'(bus.fifo_count), 32'd3);
    tick();
    expect_wr(5'd4, 32'h103); tick();
    expect_wr(5'd5, 32'h105); tick(); settle();
    chk("full_drained", 32'(bus.fifo_count), 32'd0);

    // Squash by a later pipeline write to the same register
    bus.raddr1 = 5'd9;
    pipe(1'b1, 5'd8, 32'h88); lu(1'b1, 5'd9, 32'h1111); expect_wr(5'd8, 32'h88);
    tick();
    lu(1'b0, 5'd0, 32'h0); pipe(1'b1, 5'd9, 32'h2222); expect_wr(5'd9, 32'h2222); settle();
    chk("squash_busy_before", 32'(bus.busy1), 32'd1);
    tick();
    pipe(1'b0, 5'd0, 32'h0); settle();
    chk("squash_busy_after", 32'(bus.busy1), 32'd0);
    chk("squash_count", 32'(bus.fifo_count), 32'd1);
    tick(); settle();
    chk("squash_pop_count", 32'(bus.fifo_count), 32'd0);
    chk("squash_pop_we", 32'(bus.we), 32'd0);

    // Squash of an entry enqueued in the same cycle
    bus.raddr1 = 5'd6;
    pipe(1'b1, 5'd6, 32'h77); lu(1'b1, 5'd6, 32'h66); expect_wr(5'd6, 32'h77);
    tick();
    pipe(1'b0, 5'd0, 32'h0); lu(1'b0, 5'd0, 32'h0); settle();
    chk("same_squash_count", 32'(bus.fifo_count), 32'd1);
    chk("same_squash_busy", 32'(bus.busy1), 32'd0);
    tick(); settle();
    chk("same_squash_we", 32'(bus.we), 32'd0);

    // Address 0 from both sources is dropped
    bus.raddr1 = 5'd0;
    pipe(1'b1, 5'd0, 32'hDEAD); lu(1'b1, 5'd0, 32'hBEEF);
    tick();
    pipe(1'b0, 5'd0, 32'h0); lu(1'b0, 5'd0, 32'h0); settle();
    chk("addr0_count", 32'(bus.fifo_count), 32'd0);
    chk("addr0_we", 32'(bus.we), 32'd0);
    chk("addr0_busy", 32'(bus.busy1), 32'd0);

    // Stream ten entries so the pointers wrap several times
    bus.re2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lu(1'b1, ADDR_W'(11 + i), DATA_W'(32'hC000 + i));
      if (i > 0) begin
        expect_wr(ADDR_W'(10 + i), DATA_W'(32'hC000 + i - 1));
        settle();
        chk("wrap_count", 32'(bus.fifo_count), 32'd1);
      end
      if (i == 5) begin
        bus.raddr1 = 5'd15; bus.raddr2 = 5'd16; settle();
        chk("wrap_busy_queued", 32'(bus.busy1), 32'd1);
        chk("wrap_busy_enqueuing", 32'(bus.busy2), 32'd0);
      end
      tick();
    end
    lu(1'b0, 5'd0, 32'h0); expect_wr(5'd20, 32'hC009);
    tick(); settle();
    chk("wrap_empty", 32'(bus.fifo_count), 32'd0);
    tick(); settle();
    chk("idle_we", 32'(bus.we), 32'd0);
    chk("idle_waddr_hold", 32'(bus.waddr), 32'd20);
    chk("idle_wdata_hold", bus.wdata, 32'hC009);

    tick(); tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
